fetch_stage: RTL

- Instruction-fetch stage feeding the IF/ID pipeline register. Drives PC+4 and Instruction into that register.
- Owns the program counter. Issues one outstanding request at a time to the instruction memory/cache over a req/ack handshake.
- Absorbs variable memory latency and downstream freeze with a one-entry output buffer plus a one-entry skid register.
- Applies branch redirects from the execute stage. A response that is in flight when a redirect arrives is discarded.

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 17 +
 rtl/fetch_stage_skid_buf.sv | 60 ++++++
 rtl/fetch_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// +------------------------------------------------------------------+
// | fetch_stage_pkg: shared constants, state encoding and entry type  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE000_0000;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_SKID = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// +------------------------------------------------------------------+
// | fetch_stage_if: instruction-memory req/ack handshake              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_stage_skid_buf.sv
// +------------------------------------------------------------------+
// | fetch_skid_buf: one-entry output buffer backed by a skid register |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  fetch_entry_t data_i,
  input  logic         consume_i,
  input  logic         clear_i,
  output fetch_entry_t data_o,
  output logic         valid_o
);

  fetch_entry_t buf_q;
  fetch_entry_t skid_q;
  logic         buf_valid_q;
  logic         skid_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q        <= '0;
      skid_q       <= '0;
      buf_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (clear_i) begin
      buf_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (consume_i) begin
      // Refill order: parked skid word first, then a same-edge load.
      if (skid_valid_q) begin
        buf_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (load_i) begin
        buf_q <= data_i;
      end else begin
        buf_valid_q <= 1'b0;
      end
    end else if (load_i) begin
      if (buf_valid_q) begin
        skid_q       <= data_i;
        skid_valid_q <= 1'b1;
      end else begin
        buf_q       <= data_i;
        buf_valid_q <= 1'b1;
      end
    end
  end

  assign data_o  = buf_q;
  assign valid_o = buf_valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +------------------------------------------------------------------+
// | fetch_stage: PC owner, single-outstanding imem fetch, IF/ID feed  |
// | Optional perf counters with macro IF_PERF_CNT_EN. Revision: 1.0   |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branch_taken,
  input  logic [31:0]  branch_addr,
  fetch_stage_if.master imem,
  output logic [31:0]  PC,
  output logic [31:0]  Instruction,
  output logic         if_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall_cycles,
`endif
  output logic         fetch_stall
);

  import fetch_stage_pkg::*;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  target_q;
  logic         req_q;

  logic         ack_fire;
  logic         consume;
  logic         load;
  logic [31:0]  branch_tgt;
  logic [31:0]  pc_plus4;
  fetch_entry_t buf_data;

  assign branch_tgt = word_align(branch_addr);
  assign pc_plus4   = pc_q + 32'd4;
  assign ack_fire   = req_q && imem.ack;
  assign consume    = if_valid && !freeze;
  assign load       = ack_fire && (state_q == S_RUN) && !branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RUN;
      pc_q     <= word_align(RESET_PC);
      target_q <= word_align(RESET_PC);
      req_q    <= 1'b0;
    end else if (branch_taken) begin
      // A pending request cannot be withdrawn; wait out its ack in S_DROP.
      if ((state_q == S_RUN) && req_q && !ack_fire) begin
        target_q <= branch_tgt;
        state_q  <= S_DROP;
      end else if ((state_q == S_DROP) && !ack_fire) begin
        target_q <= branch_tgt;
      end else begin
        pc_q    <= branch_tgt;
        state_q <= S_RUN;
        req_q   <= 1'b1;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          req_q <= 1'b1;
          if (ack_fire) begin
            pc_q <= pc_plus4;
            if (if_valid && freeze) begin
              state_q <= S_SKID;
              req_q   <= 1'b0;
            end
          end
        end
        S_SKID: begin
          if (consume) begin
            state_q <= S_RUN;
            req_q   <= 1'b1;
          end
        end
        S_DROP: begin
          if (ack_fire) begin
            pc_q    <= target_q;
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q <= S_RUN;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  fetch_skid_buf u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .data_i    ({pc_plus4, imem.rdata}),
    .consume_i (consume),
    .clear_i   (branch_taken),
    .data_o    (buf_data),
    .valid_o   (if_valid)
  );

  assign imem.req    = req_q;
  assign imem.addr   = pc_q;
  assign PC          = if_valid ? buf_data.pc : 32'h0;
  assign Instruction = if_valid ? buf_data.instr : NOP_INSTR;
  assign fetch_stall = rst && !if_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      if (load && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (fetch_stall && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

`default_nettype wire
